multi_lane_engine: RTL and testbench

- Parametrised successor to the single-lane shift-and-score datapath.
- Runs NUM_LANES note lanes, each a LANE_DEPTH-bit shift register loaded from a pattern bus and advanced on a one-cycle step pulse.
- Per-lane press edge detection and note consumption.
- Saturating signed-penalty score, a combo counter, and game-over detection.
- Sits between the rate divider (step source) and the score display / VGA renderer.

---
 rtl/utt_pkg.sv | 40 ++++
 rtl/lane_slot.sv | 75 +++++++
 rtl/multi_lane_engine.sv | 138 +++++++++++++
 tb/tb_multi_lane_engine.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/utt_pkg.sv
// Shared types and arithmetic helpers for the multi-lane note engine.
// Holds the engine state encoding, popcount and saturating update.
package utt_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PAUSE = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int MAX_LANES = 8;

   function automatic int popcount(input logic [MAX_LANES-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < MAX_LANES; i++) begin
         n = n + int'(v[i]);
      end
      return n;
   endfunction

   // acc + add - sub, clamped to [0, hi]
   function automatic int sat_add_sub(
      input int acc,
      input int add,
      input int sub,
      input int hi
   );
      int t;
      t = acc + add - sub;
      if (t < 0) begin
         t = 0;
      end else if (t > hi) begin
         t = hi;
      end
      return t;
   endfunction

endpackage

// File: rtl/lane_slot.sv
// One note lane: shift register, press edge detector, hit/miss pulses.
// Exposes both the raw events and their registered one-cycle pulses.
module lane_slot
   import utt_pkg::*;
#(
   parameter int LANE_DEPTH = 26
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  active,
   input  logic                  step,
   input  logic                  load,
   input  logic [LANE_DEPTH-1:0] pattern_i,
   input  logic                  press_i,
   output logic [LANE_DEPTH-1:0] lane_o,
   output logic [LANE_DEPTH-1:0] lane_d_o,
   output logic                  hit_ev_o,
   output logic                  miss_ev_o,
   output logic                  hit_o,
   output logic                  miss_o
);

   logic [LANE_DEPTH-1:0] lane_q, lane_d;
   logic                  press_q, press_d;
   logic                  hit_q, hit_d;
   logic                  miss_q, miss_d;
   logic                  rise;

   // Judge the front slot against a fresh press or a scroll-out
   always_comb begin
      rise      = press_i & ~press_q;
      hit_ev_o  = active & rise & lane_q[0];
      miss_ev_o = active & ((rise & ~lane_q[0]) |
                            (step & lane_q[0] & ~hit_ev_o));
      hit_d     = hit_ev_o;
      miss_d    = miss_ev_o;
      press_d   = press_i;
   end

   // Next lane contents: reload, consume the hit note, then scroll
   always_comb begin
      lane_d = lane_q;
      if (load) begin
         lane_d = pattern_i;
      end else if (active) begin
         if (hit_ev_o) begin
            lane_d[0] = 1'b0;
         end
         if (step) begin
            lane_d = lane_d >> 1;
         end
      end
   end

   // Lane, press history and pulse registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         lane_q  <= '0;
         press_q <= 1'b0;
         hit_q   <= 1'b0;
         miss_q  <= 1'b0;
      end else begin
         lane_q  <= lane_d;
         press_q <= press_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
      end
   end

   assign lane_o   = lane_q;
   assign lane_d_o = lane_d;
   assign hit_o    = hit_q;
   assign miss_o   = miss_q;

endmodule

// File: rtl/multi_lane_engine.sv
// Multi-lane shift-and-score engine: lanes, FSM, score and combo.
// Lanes judge notes locally; the top aggregates and sequences play.
module multi_lane_engine
   import utt_pkg::*;
#(
   parameter int NUM_LANES  = 4,
   parameter int LANE_DEPTH = 26,
   parameter int SCORE_W    = 8,
   parameter int COMBO_W    = 6,
   parameter int HIT_PTS    = 1,
   parameter int MISS_PTS   = 1
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic                            step,
   input  logic                            running,
   input  logic                            load,
   input  logic [NUM_LANES*LANE_DEPTH-1:0] pattern,
   input  logic [NUM_LANES-1:0]            press,
   output logic [NUM_LANES*LANE_DEPTH-1:0] lanes,
   output logic [SCORE_W-1:0]              score,
   output logic [COMBO_W-1:0]              combo,
   output logic [NUM_LANES-1:0]            hit,
   output logic [NUM_LANES-1:0]            miss,
   output logic                            done
);

   localparam int PW        = NUM_LANES * LANE_DEPTH;
   localparam int SCORE_MAX = (1 << SCORE_W) - 1;
   localparam int COMBO_MAX = (1 << COMBO_W) - 1;

   state_e               state_q, state_d;
   logic                 done_q, done_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [COMBO_W-1:0]   combo_q, combo_d;
   logic                 active;
   logic [NUM_LANES-1:0] hit_ev, miss_ev;
   logic [PW-1:0]        lanes_d;
   int                   h_cnt, m_cnt;

   // A pause or reload in the same cycle suppresses all play
   assign active = (state_q == RUN) && running && !load;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      lane_slot #(
         .LANE_DEPTH(LANE_DEPTH)
      ) u_lane (
         .clk      (clk),
         .resetn   (resetn),
         .active   (active),
         .step     (step),
         .load     (load),
         .pattern_i(pattern[i*LANE_DEPTH +: LANE_DEPTH]),
         .press_i  (press[i]),
         .lane_o   (lanes[i*LANE_DEPTH +: LANE_DEPTH]),
         .lane_d_o (lanes_d[i*LANE_DEPTH +: LANE_DEPTH]),
         .hit_ev_o (hit_ev[i]),
         .miss_ev_o(miss_ev[i]),
         .hit_o    (hit[i]),
         .miss_o   (miss[i])
      );
   end

   // Score and combo follow this cycle's hit/miss counts
   always_comb begin
      h_cnt   = popcount(MAX_LANES'(hit_ev));
      m_cnt   = popcount(MAX_LANES'(miss_ev));
      score_d = score_q;
      combo_d = combo_q;
      if (load) begin
         score_d = '0;
         combo_d = '0;
      end else if (active) begin
         score_d = SCORE_W'(sat_add_sub(int'(score_q),
                                        HIT_PTS * h_cnt,
                                        MISS_PTS * m_cnt,
                                        SCORE_MAX));
         if (m_cnt > 0) begin
            combo_d = '0;
         end else begin
            combo_d = COMBO_W'(sat_add_sub(int'(combo_q),
                                           h_cnt, 0,
                                           COMBO_MAX));
         end
      end
   end

   // Next state: load always wins, DONE once every lane drains
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = PAUSE;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            PAUSE: begin
               if (running) state_d = RUN;
            end
            RUN: begin
               if (!running) begin
                  state_d = PAUSE;
               end else if (lanes_d == '0) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
      done_d = (state_d == DONE);
   end

   // State, registered done flag, score and combo
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
         score_q <= '0;
         combo_q <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         score_q <= score_d;
         combo_q <= combo_d;
      end
   end

   assign score = score_q;
   assign combo = combo_q;
   assign done  = done_q;

endmodule

// File: tb/tb_multi_lane_engine.sv
// Directed and random stimulus for multi_lane_engine.
// Outputs are compared every cycle against a behavioural game model.
module tb_multi_lane_engine;

   localparam int NL = 4;
   localparam int LD = 26;
   localparam int SW = 4;
   localparam int CW = 2;
   localparam int HP = 1;
   localparam int MP = 1;
   localparam int PW = NL * LD;

   localparam int M_IDLE  = 0;
   localparam int M_PAUSE = 1;
   localparam int M_RUN   = 2;
   localparam int M_DONE  = 3;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          step = 1'b0;
   logic          running = 1'b0;
   logic          load = 1'b0;
   logic [PW-1:0] pattern = '0;
   logic [NL-1:0] press = '0;
   logic [PW-1:0] lanes;
   logic [SW-1:0] score;
   logic [CW-1:0] combo;
   logic [NL-1:0] hit;
   logic [NL-1:0] miss;
   logic          done;

   int n_asserts = 0;
   int n_fail = 0;

   logic [LD-1:0] m_lane[NL];
   int            m_score, m_combo, m_mode;
   logic [NL-1:0] m_pp, m_hit, m_miss;

   multi_lane_engine #(
      .NUM_LANES(NL), .LANE_DEPTH(LD), .SCORE_W(SW),
      .COMBO_W(CW), .HIT_PTS(HP), .MISS_PTS(MP)
   ) dut (
      .clk(clk), .resetn(resetn), .step(step),
      .running(running), .load(load), .pattern(pattern),
      .press(press), .lanes(lanes), .score(score),
      .combo(combo), .hit(hit), .miss(miss), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [PW-1:0] m_pack();
      logic [PW-1:0] v;
      for (int i = 0; i < NL; i++) v[i*LD +: LD] = m_lane[i];
      return v;
   endfunction

   // Game rules applied to the inputs present at this clock edge
   task automatic model_step();
      int h, mc, t;
      bit any;
      bit rise, front;
      m_hit  = '0;
      m_miss = '0;
      if (!resetn) begin
         for (int i = 0; i < NL; i++) m_lane[i] = '0;
         m_score = 0; m_combo = 0;
         m_mode = M_IDLE; m_pp = '0;
         return;
      end
      if (load) begin
         for (int i = 0; i < NL; i++) m_lane[i] = pattern[i*LD +: LD];
         m_score = 0; m_combo = 0; m_mode = M_PAUSE;
      end else if (m_mode == M_RUN && !running) begin
         m_mode = M_PAUSE;
      end else if (m_mode == M_RUN) begin
         for (int i = 0; i < NL; i++) begin
            rise  = press[i] && !m_pp[i];
            front = m_lane[i][0];
            if (rise && front) begin
               m_hit[i] = 1'b1;
               m_lane[i][0] = 1'b0;
            end else if (rise) begin
               m_miss[i] = 1'b1;
            end
            if (step && front && !m_hit[i]) m_miss[i] = 1'b1;
            if (step) m_lane[i] = m_lane[i] >> 1;
         end
         h  = $countones(m_hit);
         mc = $countones(m_miss);
         t  = m_score + HP * h - MP * mc;
         m_score = (t < 0) ? 0 : (t > 2**SW - 1) ? 2**SW - 1 : t;
         if (mc > 0) m_combo = 0;
         else m_combo = (m_combo + h > 2**CW - 1) ? 2**CW - 1 : m_combo + h;
         any = 1'b0;
         for (int i = 0; i < NL; i++) if (m_lane[i] != '0) any = 1'b1;
         if (!any) m_mode = M_DONE;
      end else if (m_mode == M_PAUSE && running) begin
         m_mode = M_RUN;
      end
      m_pp = press;
   endtask

   task automatic check_all();
      n_asserts++;
      assert (lanes === m_pack()) else begin
         n_fail++;
         $error("FAIL lanes got %h exp %h", lanes, m_pack());
      end
      n_asserts++;
      assert (score === SW'(m_score)) else begin
         n_fail++;
         $error("FAIL score got %0d exp %0d", score, m_score);
      end
      n_asserts++;
      assert (combo === CW'(m_combo)) else begin
         n_fail++;
         $error("FAIL combo got %0d exp %0d", combo, m_combo);
      end
      n_asserts++;
      assert (hit === m_hit) else begin
         n_fail++;
         $error("FAIL hit got %b exp %b", hit, m_hit);
      end
      n_asserts++;
      assert (miss === m_miss) else begin
         n_fail++;
         $error("FAIL miss got %b exp %b", miss, m_miss);
      end
      n_asserts++;
      assert (done === (m_mode == M_DONE)) else begin
         n_fail++;
         $error("FAIL done got %b exp %b", done, m_mode == M_DONE);
      end
   endtask

   task automatic expect_val(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
      n_asserts++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic drive(input logic s, input logic r, input logic l,
                        input logic [NL-1:0] p);
      step = s; running = r; load = l; press = p;
      tick();
   endtask

   function automatic logic [PW-1:0] mk_pat(input logic [LD-1:0] l0,
      input logic [LD-1:0] l1, input logic [LD-1:0] l2,
      input logic [LD-1:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   initial begin
      // reset
      resetn = 1'b0;
      drive(0, 0, 0, '0);
      drive(0, 0, 0, '0);
      expect_val("rst_done", 128'(done), 128'd0);
      expect_val("rst_score", 128'(score), 128'd0);
      expect_val("rst_lanes", 128'(lanes), 128'd0);
      resetn = 1'b1;

      // single note hit drains the board
      pattern = mk_pat(26'd1, 26'd0, 26'd0, 26'd0);
      drive(0, 0, 1, '0);
      drive(0, 1, 0, '0);
      drive(0, 1, 0, 4'b0001);
      expect_val("hit0_hit", 128'(hit), 128'h1);
      expect_val("hit0_score", 128'(score), 128'd1);
      expect_val("hit0_combo", 128'(combo), 128'd1);
      expect_val("hit0_lanes", 128'(lanes), 128'd0);
      expect_val("hit0_done", 128'(done), 128'd1);

      // scroll-out miss with score floored at 0
      pattern = mk_pat(26'd0, 26'd3, 26'd0, 26'd0);
      drive(0, 0, 1, '0);
      drive(0, 1, 0, '0);
      drive(1, 1, 0, '0);
      expect_val("miss1_miss", 128'(miss), 128'b0010);
      expect_val("miss1_score", 128'(score), 128'd0);
      expect_val("miss1_combo", 128'(combo), 128'd0);
      expect_val("miss1_lane1", 128'(lanes[LD +: LD]), 128'd1);

      // simultaneous hit, false press and step at score 3
      pattern = mk_pat(26'd3, 26'd1, 26'd32, 26'd1);
      drive(0, 0, 1, '0);
      drive(0, 1, 0, '0);
      drive(0, 1, 0, 4'b1011);
      expect_val("tri_score", 128'(score), 128'd3);
      drive(0, 1, 0, '0);
      drive(1, 1, 0, '0);
      drive(1, 1, 0, 4'b0101);
      expect_val("mix_hit", 128'(hit), 128'b0001);
      expect_val("mix_miss", 128'(miss), 128'b0100);
      expect_val("mix_score", 128'(score), 128'd3);
      expect_val("mix_combo", 128'(combo), 128'd0);

      // pause ignores step and presses; held press gives no hit
      pattern = mk_pat(26'd9, 26'd4, 26'd0, 26'd0);
      drive(0, 0, 1, '0);
      for (int i = 0; i < 20; i++) begin
         drive(1'($urandom), 0, 0, NL'($urandom));
      end
      expect_val("pause_lanes", 128'(lanes), 128'(pattern));
      expect_val("pause_score", 128'(score), 128'd0);
      drive(0, 0, 0, 4'b0001);
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 0, 4'b0001);
         expect_val("held_hit", 128'(hit), 128'd0);
      end
      expect_val("held_lane0", 128'(lanes[0 +: LD]), 128'd9);

      // score and combo saturation
      pattern = mk_pat(26'hff, 26'hff, 26'hff, 26'hff);
      drive(0, 0, 1, '0);
      drive(0, 1, 0, '0);
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 0, 4'b1111);
         drive(1, 1, 0, 4'b0000);
      end
      expect_val("sat_score", 128'(score), 128'd15);
      expect_val("sat_combo", 128'(combo), 128'd3);
      expect_val("sat_miss", 128'(miss), 128'd0);

      // reset in the middle of play
      resetn = 1'b0;
      drive(0, 1, 0, '0);
      expect_val("mrst_score", 128'(score), 128'd0);
      expect_val("mrst_lanes", 128'(lanes), 128'd0);
      expect_val("mrst_done", 128'(done), 128'd0);
      resetn = 1'b1;

      // random play
      for (int c = 0; c < 3000; c++) begin
         logic [PW-1:0] p;
         for (int i = 0; i < NL; i++)
            p[i*LD +: LD] = LD'($urandom & $urandom & $urandom);
         pattern = p;
         resetn  = ($urandom_range(0, 299) != 0);
         drive(($urandom_range(0, 2) == 0),
               ($urandom_range(0, 9) != 0),
               ($urandom_range(0, 59) == 0),
               NL'($urandom & $urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asserts, n_fail);
      $finish;
   end

endmodule
